// File: rtl/branch_perf_monitor_if.sv
// Retire/branch event inputs and snapshot report port of the branch performance monitor.
// master = event source and report sink, slave = the monitor itself.
interface branch_perf_monitor_if #(parameter int CNT_W = 32);
  logic              retire_valid;
  logic [31:0]       retire_inst;
  logic              stall;
  logic              mispredict;
  logic [31:0]       mispredict_inst;
  logic              rpt_valid;
  logic              rpt_ready;
  logic [CNT_W-1:0]  rpt_inst, rpt_branch, rpt_cond, rpt_mispred, rpt_repeat, rpt_cycles, rpt_stall;
  logic              rpt_overrun;

  modport master (
    output retire_valid, retire_inst, stall, mispredict, mispredict_inst, rpt_ready,
    input  rpt_valid, rpt_inst, rpt_branch, rpt_cond, rpt_mispred, rpt_repeat,
           rpt_cycles, rpt_stall, rpt_overrun
  );
  modport slave (
    input  retire_valid, retire_inst, stall, mispredict, mispredict_inst, rpt_ready,
    output rpt_valid, rpt_inst, rpt_branch, rpt_cond, rpt_mispred, rpt_repeat,
           rpt_cycles, rpt_stall, rpt_overrun
  );
endinterface

// File: rtl/branch_perf_monitor.sv
// Windowed branch/retire performance counters with a frozen valid/ready snapshot per
// WINDOW retired instructions and repeat-mispredict detection.
module branch_perf_monitor #(
  parameter int CNT_W      = 32,
  parameter int WINDOW     = 1000,
  parameter int REPEAT_WIN = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  branch_perf_monitor_if.slave mon
);
  localparam int NC = 7;
  localparam int C_INST = 0, C_BR = 1, C_COND = 2, C_MP = 3, C_REP = 4, C_CYC = 5, C_STL = 6;
  localparam logic [31:0] BUBBLE = 32'h0000_0033;
  localparam logic [6:0]  OP_BR = 7'b1100011, OP_JAL = 7'b1101111, OP_JALR = 7'b1100111;

  logic [NC-1:0][CNT_W-1:0] cnt, cnt_nxt, rpt;
  logic [NC-1:0]            ev;
  logic [6:0]               opc;
  logic                     counted, rep_hit, close, load, accept;
  logic                     rpt_valid_q, rpt_overrun_q;
  logic                     mp_have;
  logic [31:0]              mp_last;
  logic [3:0]               mp_age;

  always_comb begin
    opc     = mon.retire_inst[6:0];
    counted = mon.retire_valid && (mon.retire_inst != BUBBLE);
    rep_hit = mon.mispredict && mp_have && (mon.mispredict_inst == mp_last) &&
              (mp_age <= 4'(REPEAT_WIN));
    ev         = '0;
    ev[C_INST] = counted;
    ev[C_BR]   = counted && (opc == OP_BR || opc == OP_JAL || opc == OP_JALR);
    ev[C_COND] = counted && (opc == OP_BR);
    ev[C_MP]   = mon.mispredict;
    ev[C_REP]  = rep_hit;
    ev[C_CYC]  = 1'b1;
    ev[C_STL]  = mon.stall;
    // Saturating increment; the snapshot copies these so same-cycle events are included.
    for (int i = 0; i < NC; i++)
      cnt_nxt[i] = (ev[i] && !(&cnt[i])) ? cnt[i] + CNT_W'(1) : cnt[i];
    close  = !clear && counted && (cnt_nxt[C_INST] == CNT_W'(WINDOW));
    accept = rpt_valid_q && mon.rpt_ready;
    load   = close && (!rpt_valid_q || mon.rpt_ready);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              cnt <= '0;
    else if (clear || close) cnt <= '0;
    else                     cnt <= cnt_nxt;
  end

  // Repeat-detection history survives window close; only clear/reset forget it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mp_have <= 1'b0;
      mp_last <= '0;
      mp_age  <= 4'd15;
    end else if (clear) begin
      mp_have <= 1'b0;
      mp_age  <= 4'd15;
    end else if (mon.mispredict) begin
      mp_have <= 1'b1;
      mp_last <= mon.mispredict_inst;
      mp_age  <= 4'd1;
    end else if (mp_age != 4'd15) begin
      mp_age  <= mp_age + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rpt           <= '0;
      rpt_valid_q   <= 1'b0;
      rpt_overrun_q <= 1'b0;
    end else if (clear) begin
      rpt           <= '0;
      rpt_valid_q   <= 1'b0;
      rpt_overrun_q <= 1'b0;
    end else if (load) begin
      rpt           <= cnt_nxt;
      rpt_valid_q   <= 1'b1;
    end else begin
      // A close that cannot load means the old snapshot is still pending.
      if (close)  rpt_overrun_q <= 1'b1;
      if (accept) rpt_valid_q   <= 1'b0;
    end
  end

  assign mon.rpt_valid   = rpt_valid_q;
  assign mon.rpt_overrun = rpt_overrun_q;
  assign mon.rpt_inst    = rpt[C_INST];
  assign mon.rpt_branch  = rpt[C_BR];
  assign mon.rpt_cond    = rpt[C_COND];
  assign mon.rpt_mispred = rpt[C_MP];
  assign mon.rpt_repeat  = rpt[C_REP];
  assign mon.rpt_cycles  = rpt[C_CYC];
  assign mon.rpt_stall   = rpt[C_STL];
endmodule

// File: tb/tb_branch_perf_monitor.sv
// Directed + random bench for branch_perf_monitor against an event-level reference model.
module tb_branch_perf_monitor;
  localparam int CNT_W = 5, WINDOW = 8, RW = 4;
  localparam int SAT = (1 << CNT_W) - 1;
  localparam logic [31:0] NOP = 32'h0000_0013, BUB = 32'h0000_0033;
  localparam logic [31:0] MA = 32'hfe05_96e3, MB = 32'h00b5_0463, MC = 32'h1234_5663;

  logic clk = 1'b0, rst_n = 1'b1, clear = 1'b0;
  always #5 clk = ~clk;

  branch_perf_monitor_if #(.CNT_W(CNT_W)) bus();
  branch_perf_monitor #(.CNT_W(CNT_W), .WINDOW(WINDOW), .REPEAT_WIN(RW)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .mon(bus));

  int n_cmp = 0, n_bad = 0;
  // model: 0 inst,1 branch,2 cond,3 mispred,4 repeat,5 cycles,6 stall
  int m_cnt[7], m_rpt[7];
  bit m_rv, m_ov, m_have;
  logic [31:0] m_last;
  int m_last_cyc, m_cyc;
  string nm[7] = '{"inst", "branch", "cond", "mispred", "repeat", "cycles", "stall"};

  function automatic int sadd(int v, bit e);
    return (e && v < SAT) ? v + 1 : v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    foreach (m_cnt[k]) begin m_cnt[k] = 0; m_rpt[k] = 0; end
    m_rv = 0; m_ov = 0; m_have = 0;
  endtask

  // One clock of the model, from the inputs as they stand at the edge.
  task automatic model_edge();
    int n[7]; bit counted, close, acc, rep; logic [6:0] op; int age;
    m_cyc++;
    if (clear) begin
      foreach (m_cnt[k]) m_cnt[k] = 0;
      m_rv = 0; m_ov = 0; m_have = 0;
      return;
    end
    counted = bus.retire_valid && bus.retire_inst != BUB;
    op  = bus.retire_inst[6:0];
    age = (m_cyc - m_last_cyc > 15) ? 15 : m_cyc - m_last_cyc;
    rep = bus.mispredict && m_have && bus.mispredict_inst == m_last && age <= RW;
    n[0] = sadd(m_cnt[0], counted);
    n[1] = sadd(m_cnt[1], counted && (op == 7'h63 || op == 7'h6f || op == 7'h67));
    n[2] = sadd(m_cnt[2], counted && op == 7'h63);
    n[3] = sadd(m_cnt[3], bus.mispredict);
    n[4] = sadd(m_cnt[4], rep);
    n[5] = sadd(m_cnt[5], 1'b1);
    n[6] = sadd(m_cnt[6], bus.stall);
    if (bus.mispredict) begin m_have = 1; m_last = bus.mispredict_inst; m_last_cyc = m_cyc; end
    close = counted && n[0] == WINDOW;
    acc   = m_rv && bus.rpt_ready;
    if (close) begin
      if (m_rv && !acc) m_ov = 1;
      else begin m_rpt = n; m_rv = 1; end
      foreach (m_cnt[k]) m_cnt[k] = 0;
    end else begin
      m_cnt = n;
      if (acc) m_rv = 0;
    end
  endtask

  task automatic check_outputs();
    logic [CNT_W-1:0] f[7];
    f = '{bus.rpt_inst, bus.rpt_branch, bus.rpt_cond, bus.rpt_mispred,
          bus.rpt_repeat, bus.rpt_cycles, bus.rpt_stall};
    chk("rpt_valid", bus.rpt_valid, m_rv);
    chk("rpt_overrun", bus.rpt_overrun, m_ov);
    if (m_rv) for (int k = 0; k < 7; k++) chk({"rpt_", nm[k]}, f[k], m_rpt[k]);
  endtask

  task automatic drv(input bit rv, input logic [31:0] ri, input bit st, input bit mp,
                     input logic [31:0] mi, input bit rdy);
    bus.retire_valid = rv; bus.retire_inst = ri; bus.stall = st;
    bus.mispredict = mp; bus.mispredict_inst = mi; bus.rpt_ready = rdy;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic retires(input int n, input logic [31:0] ri, input bit rdy);
    for (int i = 0; i < n; i++) begin drv(1, ri, 0, 0, 0, rdy); step(); end
  endtask

  task automatic all_zero(input string tag);
    chk({tag, "_valid"}, bus.rpt_valid, 0);
    chk({tag, "_overrun"}, bus.rpt_overrun, 0);
    chk({tag, "_inst"}, bus.rpt_inst, 0);
    chk({tag, "_mispred"}, bus.rpt_mispred, 0);
    chk({tag, "_cycles"}, bus.rpt_cycles, 0);
    chk({tag, "_stall"}, bus.rpt_stall, 0);
  endtask

  initial begin
    drv(0, NOP, 0, 0, 0, 1);
    model_reset(); m_cyc = 0; m_last_cyc = 0; m_last = '0;
    #1 rst_n = 1'b0;
    #5 all_zero("reset");
    #1 rst_n = 1'b1;

    // clean window: 8 retires over 10 cycles, 2 stalls
    for (int i = 0; i < 10; i++) begin
      if (i == 3 || i == 6) drv(0, NOP, 1, 0, 0, 1); else drv(1, NOP, 0, 0, 0, 1);
      step();
    end
    chk("clean_valid", bus.rpt_valid, 1);
    chk("clean_inst", bus.rpt_inst, 8);
    chk("clean_branch", bus.rpt_branch, 0);
    chk("clean_cycles", bus.rpt_cycles, 10);
    chk("clean_stall", bus.rpt_stall, 2);

    // classification and bubbles
    retires(1, 32'h0006_8463, 1); retires(1, 32'h0000_006f, 1); retires(1, 32'h0000_8067, 1);
    retires(3, BUB, 1); retires(5, NOP, 1);
    chk("class_branch", bus.rpt_branch, 3);
    chk("class_cond", bus.rpt_cond, 1);
    chk("class_inst", bus.rpt_inst, 8);
    chk("class_cycles", bus.rpt_cycles, 11);

    // repeat mispredicts at offsets 0,4 (repeat), 9 (too old), 10 (different inst)
    for (int i = 0; i < 19; i++) begin
      drv(i >= 11, NOP, 0, i == 0 || i == 4 || i == 9 || i == 10, (i == 10) ? MB : MA, 1);
      step();
    end
    chk("rep_mispred", bus.rpt_mispred, 4);
    chk("rep_repeat", bus.rpt_repeat, 1);

    // mispredict + stall on the closing retire
    retires(7, NOP, 1);
    drv(1, NOP, 1, 1, MC, 1); step();
    chk("bnd_mispred", bus.rpt_mispred, 1);
    chk("bnd_stall", bus.rpt_stall, 1);
    retires(8, NOP, 1);
    chk("bnd_next_mispred", bus.rpt_mispred, 0);
    chk("bnd_next_stall", bus.rpt_stall, 0);
    chk("bnd_next_cycles", bus.rpt_cycles, 8);

    // backpressure across two closes, third close accepted on its own cycle
    drv(0, NOP, 0, 0, 0, 1); step();
    retires(8, NOP, 0);
    chk("bp_a_valid", bus.rpt_valid, 1);
    chk("bp_a_cycles", bus.rpt_cycles, 9);
    for (int i = 0; i < 11; i++) begin
      if (i == 1 || i == 3 || i == 5) drv(0, NOP, 1, 0, 0, 0); else drv(1, NOP, 0, 0, 0, 0);
      step();
    end
    chk("bp_b_overrun", bus.rpt_overrun, 1);
    chk("bp_b_held_cycles", bus.rpt_cycles, 9);
    chk("bp_b_held_stall", bus.rpt_stall, 0);
    drv(0, NOP, 1, 0, 0, 0); step(); step();
    retires(7, NOP, 0);
    retires(1, NOP, 1);
    chk("bp_c_valid", bus.rpt_valid, 1);
    chk("bp_c_cycles", bus.rpt_cycles, 10);
    chk("bp_c_stall", bus.rpt_stall, 2);
    chk("bp_c_overrun", bus.rpt_overrun, 1);

    // asynchronous reset mid-window with a pending snapshot
    retires(3, NOP, 0);
    rst_n = 1'b0;
    #1 all_zero("midrst");
    model_reset();
    #2 rst_n = 1'b1;

    // clear dominates retire/mispredict and forgets mispredict history
    clear = 1'b1;
    for (int i = 0; i < 12; i++) begin drv(1, 32'h0006_8463, 0, 1, MA, 1); step(); end
    clear = 1'b0;
    drv(1, NOP, 0, 1, MA, 1); step();
    retires(7, NOP, 1);
    chk("clr_inst", bus.rpt_inst, 8);
    chk("clr_branch", bus.rpt_branch, 0);
    chk("clr_mispred", bus.rpt_mispred, 1);
    chk("clr_repeat", bus.rpt_repeat, 0);
    chk("clr_cycles", bus.rpt_cycles, 8);

    // random traffic; sparse-retire phases drive cycles/stall into saturation
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] ri;
      int rv_pct;
      rv_pct = ((i / 500) % 2 == 0) ? 60 : 4;
      case ($urandom_range(0, 5))
        0: ri = NOP;
        1: ri = BUB;
        2: ri = 32'h0006_8463;
        3: ri = 32'h0000_006f;
        4: ri = 32'h0000_8067;
        default: ri = $urandom;
      endcase
      drv($urandom_range(0, 99) < rv_pct, ri, $urandom_range(0, 99) < 30,
          $urandom_range(0, 99) < 15, $urandom_range(0, 1) ? MA : MB, $urandom_range(0, 1));
      clear = ($urandom_range(0, 199) == 0);
      step();
    end
    clear = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
